// File: rtl/chacha_block_core.sv
// rtl/chacha_block_core.sv - sequential ChaCha block function, one ARX micro-step per clock
module chacha_block_core #(
    parameter int DOUBLE_ROUNDS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  setRounds,
    input  logic [3:0][3:0][31:0] chachamatrixIN,
    output logic [3:0][3:0][31:0] chachamatrixOUT,
    output logic                  blockready,
    output logic [3:0]            blocksproduced
);
    localparam int CW = (DOUBLE_ROUNDS > 1) ? $clog2(DOUBLE_ROUNDS) : 1;
    localparam logic [CW-1:0] LAST_ROUND = CW'(DOUBLE_ROUNDS - 1);

    localparam logic [3:0] ST_S0   = 4'd0;
    localparam logic [3:0] ST_S1   = 4'd1;
    localparam logic [3:0] ST_S2   = 4'd2;
    localparam logic [3:0] ST_S3   = 4'd3;
    localparam logic [3:0] ST_S4   = 4'd4;
    localparam logic [3:0] ST_S5   = 4'd5;
    localparam logic [3:0] ST_S6   = 4'd6;
    localparam logic [3:0] ST_S7   = 4'd7;
    localparam logic [3:0] ST_S8   = 4'd8;
    localparam logic [3:0] ST_S9   = 4'd9;
    localparam logic [3:0] ST_S10  = 4'd10;
    localparam logic [3:0] ST_S11  = 4'd11;
    localparam logic [3:0] ST_S12  = 4'd12;
    localparam logic [3:0] ST_IDLE = 4'd13;
    localparam logic [3:0] ST_DONE = 4'd14;

    logic [3:0][3:0][31:0] init;
    logic [3:0][3:0][31:0] work;
    logic [3:0][3:0][31:0] wb;
    logic [3:0][3:0][31:0] src;
    logic [3:0][3:0][31:0] fin;
    logic [31:0]           a, b, c, d;
    logic [31:0]           na, nb, nc, nd;
    logic [3:0]            step;
    logic [2:0]            quarter;
    logic [2:0]            sel_q;
    logic [CW-1:0]         round;
    logic                  armed;

    // Row r of quarter q: columns use column q, diagonals shift one column per row.
    function automatic logic [1:0] col_of(input logic [2:0] q, input logic [1:0] row);
        return q[2] ? 2'(row + q[1:0]) : q[1:0];
    endfunction

    // wb is the state after the current quarter's write-back; the next quarter reads from it
    // so the diagonal round sees the completed column round.
    always_comb begin
        wb = work;
        wb[0][col_of(quarter, 2'd0)] = a;
        wb[1][col_of(quarter, 2'd1)] = b;
        wb[2][col_of(quarter, 2'd2)] = c;
        wb[3][col_of(quarter, 2'd3)] = d;
        sel_q = (step == ST_S12) ? 3'(quarter + 3'd1) : quarter;
        src   = (step == ST_S12) ? wb : work;
        na = src[0][col_of(sel_q, 2'd0)];
        nb = src[1][col_of(sel_q, 2'd1)];
        nc = src[2][col_of(sel_q, 2'd2)];
        nd = src[3][col_of(sel_q, 2'd3)];
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                fin[i][j] = wb[i][j] + init[i][j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init            <= '0;
            work            <= '0;
            a               <= '0;
            b               <= '0;
            c               <= '0;
            d               <= '0;
            step            <= ST_IDLE;
            quarter         <= '0;
            round           <= '0;
            armed           <= 1'b0;
            chachamatrixOUT <= '0;
            blockready      <= 1'b0;
            blocksproduced  <= '0;
        end else if (setRounds) begin
            init       <= chachamatrixIN;
            work       <= chachamatrixIN;
            step       <= ST_IDLE;
            quarter    <= '0;
            round      <= '0;
            armed      <= 1'b1;
            blockready <= 1'b0;
        end else begin
            case (step)
                ST_IDLE: begin
                    if (armed) begin
                        a    <= na;
                        b    <= nb;
                        c    <= nc;
                        d    <= nd;
                        step <= ST_S0;
                    end
                end
                ST_S0:  begin a <= a + b;                step <= ST_S1;  end
                ST_S1:  begin d <= d ^ a;                step <= ST_S2;  end
                ST_S2:  begin d <= {d[15:0], d[31:16]};  step <= ST_S3;  end
                ST_S3:  begin c <= c + d;                step <= ST_S4;  end
                ST_S4:  begin b <= b ^ c;                step <= ST_S5;  end
                ST_S5:  begin b <= {b[19:0], b[31:20]};  step <= ST_S6;  end
                ST_S6:  begin a <= a + b;                step <= ST_S7;  end
                ST_S7:  begin d <= d ^ a;                step <= ST_S8;  end
                ST_S8:  begin d <= {d[23:0], d[31:24]};  step <= ST_S9;  end
                ST_S9:  begin c <= c + d;                step <= ST_S10; end
                ST_S10: begin b <= b ^ c;                step <= ST_S11; end
                ST_S11: begin b <= {b[24:0], b[31:25]};  step <= ST_S12; end
                ST_S12: begin
                    work    <= wb;
                    a       <= na;
                    b       <= nb;
                    c       <= nc;
                    d       <= nd;
                    quarter <= sel_q;
                    step    <= ST_S0;
                    if (quarter == 3'd7) begin
                        if (round == LAST_ROUND) begin
                            chachamatrixOUT <= fin;
                            blockready      <= 1'b1;
                            blocksproduced  <= blocksproduced + 4'd1;
                            step            <= ST_DONE;
                        end else begin
                            round <= round + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_block_core.sv
// tb/tb_chacha_block_core.sv - scoreboard bench for chacha_block_core against a reference block function
module tb_chacha_block_core;
    typedef logic [3:0][3:0][31:0] mat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       setRounds;
    mat_t       chachamatrixIN;
    mat_t       chachamatrixOUT;
    logic       blockready;
    logic [3:0] blocksproduced;

    int   errors = 0;
    int   checks = 0;
    mat_t exp_q[$];

    chacha_block_core #(.DOUBLE_ROUNDS(10)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .setRounds(setRounds),
        .chachamatrixIN(chachamatrixIN),
        .chachamatrixOUT(chachamatrixOUT),
        .blockready(blockready),
        .blocksproduced(blocksproduced)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [15:0][31:0] qr(input logic [15:0][31:0] x, input int ia, input int ib,
                                             input int ic, input int id);
        x[ia] = x[ia] + x[ib]; x[id] = rotl(x[id] ^ x[ia], 16);
        x[ic] = x[ic] + x[id]; x[ib] = rotl(x[ib] ^ x[ic], 12);
        x[ia] = x[ia] + x[ib]; x[id] = rotl(x[id] ^ x[ia], 8);
        x[ic] = x[ic] + x[id]; x[ib] = rotl(x[ib] ^ x[ic], 7);
        return x;
    endfunction

    function automatic mat_t chacha_ref(input mat_t m);
        logic [15:0][31:0] x;
        mat_t              r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) x[i*4+j] = m[i][j];
        for (int k = 0; k < 10; k++) begin
            x = qr(x, 0, 4, 8, 12);  x = qr(x, 1, 5, 9, 13);
            x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
            x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12);
            x = qr(x, 2, 7, 8, 13);  x = qr(x, 3, 4, 9, 14);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) r[i][j] = x[i*4+j] + m[i][j];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load edge with setRounds=1; afterwards the input bus carries junk that must be ignored.
    task automatic load(input mat_t m);
        @(negedge clk);
        setRounds      = 1'b1;
        chachamatrixIN = m;
        @(posedge clk);
        #1;
        setRounds = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) chachamatrixIN[i][j] = $urandom;
    endtask

    task automatic wait_block(output int edge_n);
        edge_n = 0;
        for (int n = 1; n <= 1100; n++) begin
            @(posedge clk);
            #1;
            if (blockready) begin
                edge_n = n;
                break;
            end
        end
    endtask

    task automatic pop_check(input string tag);
        mat_t exp;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 512'd1, 512'd0);
        end else begin
            exp = exp_q.pop_front();
            chk(tag, chachamatrixOUT, exp);
        end
    endtask

    initial begin
        mat_t  rfc, qm, m, held;
        int    edge_n;
        logic  early;
        logic [31:0] vin[16] = '{
            32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
            32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
            32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
            32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) rfc[i][j] = vin[i*4+j];

        rst_n = 1'b0;
        setRounds = 1'b0;
        chachamatrixIN = '0;
        #22;
        chk("reset_out", chachamatrixOUT, '0);
        chk("reset_ready", 512'(blockready), 512'd0);
        chk("reset_count", 512'(blocksproduced), 512'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First quarter round on column 0
        qm = '0;
        qm[0][0] = 32'h11111111; qm[1][0] = 32'h01020304;
        qm[2][0] = 32'h9b8d6f43; qm[3][0] = 32'h01234567;
        load(qm);
        repeat (14) @(posedge clk);
        #1;
        chk("qr_a", 512'(dut.work[0][0]), 512'(32'hea2a92f4));
        chk("qr_b", 512'(dut.work[1][0]), 512'(32'hcb1cf8ce));
        chk("qr_c", 512'(dut.work[2][0]), 512'(32'h4581472e));
        chk("qr_d", 512'(dut.work[3][0]), 512'(32'h5881c4bb));

        // RFC 8439 block vector
        load(rfc);
        exp_q.push_back(chacha_ref(rfc));
        wait_block(edge_n);
        chk("rfc_latency", 512'(edge_n), 512'd1041);
        chk("rfc_row0", 512'(chachamatrixOUT[0]),
            512'({32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110}));
        chk("rfc_row3", 512'(chachamatrixOUT[3]),
            512'({32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5}));
        pop_check("rfc_block");
        chk("rfc_count", 512'(blocksproduced), 512'd1);

        // Hold in DONE
        held = chachamatrixOUT;
        repeat (2000) @(posedge clk);
        #1;
        chk("hold_out", chachamatrixOUT, held);
        chk("hold_ready", 512'(blockready), 512'd1);
        chk("hold_count", 512'(blocksproduced), 512'd1);

        // Abort at edge 500 and reload
        load(rfc);
        early = 1'b0;
        for (int n = 1; n < 500; n++) begin
            @(posedge clk);
            #1;
            if (blockready) early = 1'b1;
        end
        load(rfc);
        exp_q.push_back(chacha_ref(rfc));
        wait_block(edge_n);
        chk("abort_no_early", 512'(early), 512'd0);
        chk("abort_latency", 512'(edge_n), 512'd1041);
        pop_check("abort_block");
        chk("abort_count", 512'(blocksproduced), 512'd2);

        // Asynchronous reset mid-run, then stay idle without a load
        load(rfc);
        repeat (300) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", chachamatrixOUT, '0);
        chk("rst_mid_ready", 512'(blockready), 512'd0);
        chk("rst_mid_count", 512'(blocksproduced), 512'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_block(edge_n);
        chk("rst_idle_ready", 512'(edge_n), 512'd0);
        chk("rst_idle_count", 512'(blocksproduced), 512'd0);

        // Sixteen random blocks: counter wraps back to zero
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) m[i][j] = $urandom;
            load(m);
            exp_q.push_back(chacha_ref(m));
            wait_block(edge_n);
            chk($sformatf("wrap_latency_%0d", k), 512'(edge_n), 512'd1041);
            pop_check($sformatf("wrap_block_%0d", k));
            chk($sformatf("wrap_count_%0d", k), 512'(blocksproduced), 512'((k + 1) % 16));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
